// File: rtl/sram_like_resp_if.sv
`default_nettype none
// ============================================================================
// Module      : sram_like_resp_if
// Description : SRAM-like req/addr_ok/data_ok bus plus responder test controls.
// Revision    : 1.0 - initial release
// ============================================================================
interface sram_like_resp_if;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;
    logic        stall_i;
    logic [3:0]  delay_i;

    modport master (
        output req, wr, size, wstrb, addr, wdata, stall_i, delay_i,
        input  addr_ok, data_ok, rdata
    );

    modport slave (
        input  req, wr, size, wstrb, addr, wdata, stall_i, delay_i,
        output addr_ok, data_ok, rdata
    );
endinterface
`default_nettype wire

// File: rtl/sram_like_resp.sv
`default_nettype none
// ============================================================================
// Module      : sram_like_resp
// Description : In-order SRAM-like responder with configurable latency and
//               bounded outstanding requests. Define SRAM_RESP_RAND_STALL_EN
//               to add LFSR-driven random accept stalls and extra latency.
// Revision    : 1.0 - initial release
// ============================================================================
module sram_like_resp #(
    parameter int DEPTH_LOG2  = 12,
    parameter int OUTSTANDING = 2,
    parameter int LAT         = 1
) (
    input  wire             clk,
    input  wire             reset,
    sram_like_resp_if.slave sram
);

    localparam int                c_CW     = $clog2(OUTSTANDING + 1);
    localparam int                c_WORDS  = 1 << DEPTH_LOG2;
    localparam logic [c_CW-1:0]   c_OUT    = c_CW'(OUTSTANDING);
    localparam logic [4:0]        c_LAT_M1 = 5'(LAT - 1);

    logic [31:0]           r_mem [c_WORDS];

    // Queue is kept as a shift register: entry 0 is always the head.
    logic                  r_q_wr   [OUTSTANDING];
    logic [31:0]           r_q_data [OUTSTANDING];
    logic [4:0]            r_q_cnt  [OUTSTANDING];
    logic [c_CW-1:0]       r_count;

    logic                  w_n_wr   [OUTSTANDING];
    logic [31:0]           w_n_data [OUTSTANDING];
    logic [4:0]            w_n_cnt  [OUTSTANDING];
    logic [4:0]            w_dec    [OUTSTANDING];
    logic [c_CW-1:0]       w_n_count;

    logic [DEPTH_LOG2-1:0] w_idx;
    logic [31:0]           w_rd_word;
    logic                  w_pop;
    logic                  w_room;
    logic                  w_rand_ok;
    logic [4:0]            w_rand_cnt;
    logic                  w_addr_ok;
    logic                  w_accept;
    logic [c_CW-1:0]       w_tail;
    logic [4:0]            w_new_cnt;
    logic                  w_unused_bits;

    assign w_idx         = sram.addr[DEPTH_LOG2+1:2];
    assign w_rd_word     = r_mem[w_idx];
    assign w_unused_bits = ^{sram.size, sram.addr[31:DEPTH_LOG2+2], sram.addr[1:0]};

`ifdef SRAM_RESP_RAND_STALL_EN
    logic [15:0] r_lfsr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_lfsr <= 16'hACE1;
        end else begin
            r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
        end
    end

    assign w_rand_ok  = (r_lfsr[1:0] != 2'b00);
    assign w_rand_cnt = {2'b00, r_lfsr[4:2]};
`else
    assign w_rand_ok  = 1'b1;
    assign w_rand_cnt = 5'd0;
`endif

    assign w_pop     = (r_count != '0) && (r_q_cnt[0] == 5'd0);
    assign w_room    = (r_count < c_OUT) || w_pop;
    assign w_addr_ok = sram.req & ~sram.stall_i & w_room & w_rand_ok;
    assign w_accept  = sram.req & w_addr_ok;
    assign w_tail    = r_count - c_CW'(w_pop);
    assign w_new_cnt = c_LAT_M1 + {1'b0, sram.delay_i} + w_rand_cnt;

    assign sram.addr_ok = w_addr_ok;
    assign sram.data_ok = w_pop;
    assign sram.rdata   = (w_pop && !r_q_wr[0]) ? r_q_data[0] : 32'd0;

    always_comb begin
        for (int i = 0; i < OUTSTANDING; i++) begin
            w_dec[i]    = (r_q_cnt[i] != 5'd0) ? (r_q_cnt[i] - 5'd1) : 5'd0;
            w_n_wr[i]   = r_q_wr[i];
            w_n_data[i] = r_q_data[i];
            w_n_cnt[i]  = w_dec[i];
        end

        if (w_pop) begin
            for (int i = 0; i < OUTSTANDING - 1; i++) begin
                w_n_wr[i]   = r_q_wr[i+1];
                w_n_data[i] = r_q_data[i+1];
                w_n_cnt[i]  = w_dec[i+1];
            end
            w_n_wr[OUTSTANDING-1]   = 1'b0;
            w_n_data[OUTSTANDING-1] = 32'd0;
            w_n_cnt[OUTSTANDING-1]  = 5'd0;
        end

        // Tail slot already accounts for this cycle's pop; the new entry
        // does not decrement in its own accept cycle.
        for (int i = 0; i < OUTSTANDING; i++) begin
            if (w_accept && (w_tail == c_CW'(i))) begin
                w_n_wr[i]   = sram.wr;
                w_n_data[i] = sram.wr ? 32'd0 : w_rd_word;
                w_n_cnt[i]  = w_new_cnt;
            end
        end

        case ({w_accept, w_pop})
            2'b10:   w_n_count = r_count + c_CW'(1);
            2'b01:   w_n_count = r_count - c_CW'(1);
            default: w_n_count = r_count;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
            for (int i = 0; i < OUTSTANDING; i++) begin
                r_q_wr[i]   <= 1'b0;
                r_q_data[i] <= 32'd0;
                r_q_cnt[i]  <= 5'd0;
            end
        end else begin
            r_count <= w_n_count;
            for (int i = 0; i < OUTSTANDING; i++) begin
                r_q_wr[i]   <= w_n_wr[i];
                r_q_data[i] <= w_n_data[i];
                r_q_cnt[i]  <= w_n_cnt[i];
            end
        end
    end

    // Storage array is deliberately not reset.
    always_ff @(posedge clk) begin
        if (w_accept && sram.wr) begin
            for (int b = 0; b < 4; b++) begin
                if (sram.wstrb[b]) begin
                    r_mem[w_idx][8*b +: 8] <= sram.wdata[8*b +: 8];
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/sram_like_resp.md
Name: sram_like_resp

Overview:
- Responder (slave) end of the SRAM-like req/addr_ok/data_ok interface that the fetch and memory stages drive as initiators.
- Accepts requests, applies writes, captures read data and returns data_ok strictly in order after a configurable latency.
- Backs simulation and FPGA bring-up for inst_sram / data_sram ports; stall and delay inputs exercise initiator cancel/flush paths.

Parameters:
- DEPTH_LOG2, 12, memory size is 2^DEPTH_LOG2 32-bit words.
- OUTSTANDING, 2, max accepted-but-unreturned requests (1..4).
- LAT, 1, minimum cycles from accept edge to data_ok (>=1).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- req  in  1  request valid
- wr  in  1  1 = write, 0 = read
- size  in  2  0 = byte, 1 = half, 2 = word (informational; wstrb governs writes)
- wstrb  in  4  write byte enables
- addr  in  32  byte address
- wdata  in  32  write data
- addr_ok  out  1  request accepted this cycle (combinational)
- data_ok  out  1  response valid this cycle
- rdata  out  32  read data, valid when data_ok
- stall_i  in  1  forces addr_ok low
- delay_i  in  4  extra latency for the request accepted this cycle

Behaviour:
- Reset:
  - Queue empty, count 0, data_ok 0, rdata 0.
  - Memory contents not reset.
  - In-flight entries discarded; no data_ok is ever issued for them.
- Word index = addr[DEPTH_LOG2+1:2]; upper bits ignored, so addresses wrap. addr[1:0] ignored.
- Queue of OUTSTANDING entries {wr, rdata_cap, cnt}. head = oldest entry.
- pop = head valid & head.cnt == 0.
- addr_ok = req & ~stall_i & (count < OUTSTANDING | pop).
- accept = req & addr_ok, at most one per cycle.
- On accept:
  - Write: memory bytes with wstrb[i]=1 updated at the clock edge; rdata_cap = 0.
  - Read: rdata_cap = current memory word. Reflects every write accepted in earlier cycles.
  - Entry pushed at tail with cnt = LAT-1+delay_i, 5-bit.
- Each cycle every valid entry with cnt > 0 decrements. Younger entries count concurrently and saturate at 0.
- data_ok = pop; rdata = head.rdata_cap when pop, else 0.
  - Head is popped at the end of that cycle.
  - No back-pressure on data_ok: the initiator must take it.
- Latency: accept at cycle T, LAT=1, delay 0 -> data_ok at T+1. Generally data_ok at T+LAT+delay, or later if an older entry is still pending.
- Ordering:
  - Responses always in accept order.
  - A young entry with cnt 0 waits behind the head, then returns on the cycle after the head pops.
  - Back-to-back data_ok is allowed.
- Simultaneous:
  - Accept plus pop when full: allowed; count unchanged.
  - Accept into an empty queue: data_ok is not asserted in the same cycle.
- Writes return data_ok like reads, with rdata 0.

Optional Feature:
- SRAM_RESP_RAND_STALL_EN defined:
  - 16-bit LFSR, seed 16'hACE1 on reset, advances every cycle.
  - addr_ok is additionally masked when lfsr[1:0]==2'b00.
  - Each accepted entry gets cnt += lfsr[4:2].
  - Order and data are unchanged.
- Undefined: no LFSR; behaviour exactly as above.

Test Plan:
- Write 0x12345678 to 0x1C000000 (wstrb 1111, LAT=1) -> addr_ok same cycle, data_ok next cycle, rdata 0. Read same address -> data_ok T+1, rdata 0x12345678.
- Write wstrb 0010, wdata 0x0000AB00 to the same word -> subsequent read returns 0x1234AB78.
- OUTSTANDING=2, delay_i=7, three back-to-back reads -> first two accepted, third addr_ok=0 until the cycle the first data_ok fires, then accepted.
- Read A (delay_i 5), then read B (delay_i 0) -> B returns exactly one cycle after A's data_ok; data matches A then B.
- stall_i=1 for 3 cycles with req held -> addr_ok 0 for 3 cycles, accepted on the 4th, data_ok one cycle later.
- Reset asserted while 2 reads are in flight -> data_ok 0 immediately and after release; next read returns correctly with count restarting at 0.
